move_scheduler: RTL
===================

// Module: move_scheduler
// PURPOSE
// - Sequences the moving-block datapath: debounces four direction buttons, arbitrates simultaneous presses,
//   and issues one position-update command per MOVE_PERIOD frames, aligned to the frame boundary.
// - Sits between the board buttons and the block position/colour logic; removes the need for a slow clock.
// - Updates land only at frame_start (start of vertical blanking), so the drawn block never tears mid-frame.
// PARAMETERS
// - DEBOUNCE_CYCLES  500000  consecutive stable clk samples before a button level is accepted (5 ms @ 100 MHz)
// - MOVE_PERIOD      2       frames between repeated moves while a button is held (>=1)
// - STEP             2       pixels per move, passed through on move_step
// PORTS
// - clk          in   1   system clock; single clock domain
// - rst          in   1   synchronous, active-high reset
// - btn_right    in   1   raw button, asynchronous to clk
// - btn_left     in   1   raw button
// - btn_up       in   1   raw button
// - btn_down     in   1   raw button
// - frame_start  in   1   one-cycle pulse at start of vertical blanking
// - move_ready   in   1   consumer accepts the command this cycle
// - move_valid   out  1   command pending
// - move_dir     out  2   00 RIGHT, 01 LEFT, 10 UP, 11 DOWN; stable while move_valid
// - move_step    out  4   STEP, stable while move_valid
// - last_dir     out  2   direction of the most recent accepted move (drives background colour)
// - last_dir_vld out  1   high once any move has been accepted since reset
// BEHAVIOUR
// - Reset (rst sampled high): move_valid=0, move_dir=0, move_step=0, last_dir=0, last_dir_vld=0,
//   FSM=IDLE, frame counter=0, debounced levels=released, debounce counters=0.
// - Input path: 2-FF synchroniser per button, then debounce; the accepted level changes only after
//   DEBOUNCE_CYCLES consecutive samples differ from it; any mismatch-free sample resets the counter.
// - Priority (debounced levels): RIGHT > LEFT > UP > DOWN; opposite pairs resolve by the same order.
// - FSM:
//   IDLE  : any button pressed -> ARMED.
//   ARMED : all released -> IDLE; frame_start -> ISSUE, latch highest-priority dir, move_valid=1 next cycle.
//   ISSUE : move_valid=1; on move_valid&&move_ready -> HOLD, move_valid=0 next cycle,
//           last_dir<=move_dir, last_dir_vld<=1, frame counter<=0. Release during ISSUE does not retract.
//   HOLD  : all released -> IDLE; each frame_start increments counter; when counter reaches
//           MOVE_PERIOD-1 and a frame_start arrives -> ISSUE with freshly arbitrated dir.
// - First move latency: press accepted -> command at next frame_start +1 clk.
// - frame_start while in ISSUE (consumer stalled) is ignored; no commands queue up, at most one outstanding.
// - frame_start and release in the same cycle: release wins (ARMED/HOLD -> IDLE, no command).
// - Frame counter saturates at MOVE_PERIOD-1; width $clog2(MOVE_PERIOD+1).
// - Direction change while held: next repeat uses the new direction; no extra delay.
// CONFIGURATION
// - Macro AUTO_REPEAT_EN.
//   Defined: HOLD repeats every MOVE_PERIOD frames as above.
//   Not defined: exactly one move per press; HOLD ignores frame_start and exits only when all
//   buttons released -> IDLE; frame counter removed.
// STRUCTURE
// - Package move_pkg: dir_t enum (DIR_RIGHT=2'd0, DIR_LEFT=2'd1, DIR_UP=2'd2, DIR_DOWN=2'd3),
//   state_t enum (IDLE, ARMED, ISSUE, HOLD), priority function pick_dir(r,l,u,d).
// - Sub-module btn_debounce (synchroniser + counter, param DEBOUNCE_CYCLES), instantiated 4x.
// TESTING (DEBOUNCE_CYCLES=4, MOVE_PERIOD=2, STEP=2, move_ready tied 1 unless stated)
// - rst mid-ISSUE with btn_right held -> next cycle move_valid=0, last_dir_vld=0, FSM IDLE; no command
//   until 4+2 clk after rst release plus next frame_start.
// - btn_left glitch 3 clk high -> never accepted, no move_valid across 3 frame_starts.
// - btn_right held, 5 frame_starts (AUTO_REPEAT_EN) -> 3 commands dir=00 step=2 at frames 1,3,5;
//   without macro -> 1 command only.
// - btn_up and btn_left pressed together -> move_dir=01; last_dir=01 after handshake.
// - move_ready low for 3 frames while move_valid -> move_valid, dir, step stable; single handshake when
//   ready rises; no extra commands issued.
// - btn_down released in same cycle as frame_start in ARMED -> no command, FSM IDLE.

Source files
------------

// File: rtl/move_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg
// Shared types for the moving-block scheduler:
//   dir_t    : move direction encoding driven on move_dir / last_dir
//   state_t  : scheduler FSM states
//   pick_dir : fixed-priority arbiter over the four debounced button levels
// -----------------------------------------------------------------------------
package move_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ISSUE,
    HOLD
  } state_t;

  // RIGHT > LEFT > UP > DOWN. Opposite pairs pressed together fall out of the
  // same ordering, so no special case is needed for them.
  function automatic dir_t pick_dir(input logic r, input logic l,
                                    input logic u, input logic d);
    if (r)      return DIR_RIGHT;
    else if (l) return DIR_LEFT;
    else if (u) return DIR_UP;
    else if (d) return DIR_DOWN;
    else        return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stability counter for one raw button.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with it; a single agreeing sample restarts the count.
//
// Ports:
//   clk    in  1  system clock
//   rst    in  1  synchronous, active-high reset (level -> released)
//   btn    in  1  raw button, asynchronous to clk
//   level  out 1  debounced button level (1 = pressed)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two-stage synchroniser into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      if (sync_2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// Debounces the four direction buttons, arbitrates simultaneous presses and
// issues one position-update command per frame boundary (frame_start), so the
// block position only changes during vertical blanking.
//
// Build option: `define AUTO_REPEAT_EN to repeat the move every MOVE_PERIOD
// frames while a button is held. Without it, exactly one move is issued per
// press and the frame counter does not exist.
//
// Ports:
//   clk          in  1  system clock
//   rst          in  1  synchronous, active-high reset
//   btn_right    in  1  raw button
//   btn_left     in  1  raw button
//   btn_up       in  1  raw button
//   btn_down     in  1  raw button
//   frame_start  in  1  one-cycle pulse at start of vertical blanking
//   move_ready   in  1  consumer accepts the command this cycle
//   move_valid   out 1  command pending
//   move_dir     out 2  00 RIGHT, 01 LEFT, 10 UP, 11 DOWN; stable while valid
//   move_step    out 4  STEP while valid, 0 otherwise
//   last_dir     out 2  direction of the most recent accepted move
//   last_dir_vld out 1  high once any move has been accepted since reset
// -----------------------------------------------------------------------------
module move_scheduler
  import move_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MOVE_PERIOD     = 2,
  parameter int unsigned STEP            = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       frame_start,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] move_step,
  output logic [1:0] last_dir,
  output logic       last_dir_vld
);

  if (MOVE_PERIOD < 1) begin : g_period_check
    $error("move_scheduler: MOVE_PERIOD must be at least 1");
  end

  localparam logic [3:0] STEP_VAL = 4'(STEP);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic lvl_right, lvl_left, lvl_up, lvl_down;
  logic any_pressed;
  dir_t arb_dir;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .btn(btn_right), .level(lvl_right)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .btn(btn_left), .level(lvl_left)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn(btn_up), .level(lvl_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn(btn_down), .level(lvl_down)
  );

  assign any_pressed = lvl_right | lvl_left | lvl_up | lvl_down;
  assign arb_dir     = pick_dir(lvl_right, lvl_left, lvl_up, lvl_down);

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  dir_t   dir_q, dir_d;
  dir_t   last_dir_q, last_dir_d;
  logic   last_vld_q, last_vld_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned FCNT_W = $clog2(MOVE_PERIOD + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(MOVE_PERIOD - 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= DIR_RIGHT;
      last_dir_q <= DIR_RIGHT;
      last_vld_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      fcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      last_vld_q <= last_vld_d;
`ifdef AUTO_REPEAT_EN
      fcnt_q     <= fcnt_d;
`endif
    end
  end

  // NOTE: every signal written here is given its hold value first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    last_vld_d = last_vld_q;
`ifdef AUTO_REPEAT_EN
    fcnt_d     = fcnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_pressed) state_d = ARMED;
      end

      // Release takes precedence over a coincident frame_start.
      ARMED: begin
        if (!any_pressed) begin
          state_d = IDLE;
        end else if (frame_start) begin
          state_d = ISSUE;
          dir_d   = arb_dir;
        end
      end

      // Command stays up until accepted; a release or further frame_start
      // cannot retract or duplicate it.
      ISSUE: begin
        if (move_ready) begin
          state_d    = HOLD;
          last_dir_d = dir_q;
          last_vld_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          fcnt_d     = '0;
`endif
        end
      end

      HOLD: begin
        if (!any_pressed) begin
          state_d = IDLE;
        end
`ifdef AUTO_REPEAT_EN
        else if (frame_start) begin
          if (fcnt_q == FCNT_LAST) begin
            state_d = ISSUE;
            dir_d   = arb_dir;
          end else if (fcnt_q < FCNT_LAST) begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign move_valid   = (state_q == ISSUE);
  assign move_dir     = dir_q;
  assign move_step    = move_valid ? STEP_VAL : 4'd0;
  assign last_dir     = last_dir_q;
  assign last_dir_vld = last_vld_q;

endmodule
